serial_sub: RTL and testbench



---
 rtl/serial_sub.sv | 95 +++++++++
 tb/tb_serial_sub.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor A - B - Bin, LSB first, one full-subtractor step per clock; WIDTH cycles accept->done.
// No backpressure or queuing: start is honoured only in IDLE and ignored while busy or done.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sres, sres_nx;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, nb, last;

    // Full-subtractor cell on the current LSBs with the registered borrow
    assign d       = sa[0] ^ sb[0] ^ br;
    assign nb      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last    = (cnt == CW'(WIDTH - 1));
    assign sres_nx = (sres >> 1) | (WIDTH'(d) << (WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa   <= '0;
            sb   <= '0;
            sres <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        br   <= bin;
                        sres <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    sres <= sres_nx;
                    br   <= nb;
                    // Hold the counter on the final bit so it never wraps
                    if (!last) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        diff <= sres_nx;
                        bout <= nb;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8 and WIDTH=1 against an arithmetic reference.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start1;
    logic [7:0] a8, b8;
    logic [0:0] a1, b1;
    logic       bin8, bin1;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;
    logic       busy1, done1, bout1;
    logic [0:0] diff1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    // Reference: plain integer arithmetic, diff mod 2^w and borrow when a < b + bin
    function automatic int ref_diff(input int w, input int av, input int bv, input int binv);
        int r;
        r = av - bv - binv;
        return r & ((1 << w) - 1);
    endfunction

    function automatic int ref_bout(input int av, input int bv, input int binv);
        return (av < bv + binv) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        n_cmp++;
        if ((busy8 && done8) || (busy1 && done1)) begin
            n_bad++;
            $display("FAIL busy_done_exclusive: busy8=%0b done8=%0b busy1=%0b done1=%0b required never both high",
                     busy8, done8, busy1, done1);
        end
    end

    // Runs one operation; operands are scrambled every cycle after acceptance. lat=-1 on timeout.
    task automatic op(input int sel, input int av, input int bv, input int binv,
                      output int lat, output int dv, output int bo);
        @(negedge clk);
        if (sel == 8) begin
            start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bin8 = binv[0];
        end else begin
            start1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0]; bin1 = binv[0];
        end
        @(negedge clk);
        start8 = 1'b0;
        start1 = 1'b0;
        lat = -1; dv = -1; bo = -1;
        for (int i = 1; i <= 40; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
            @(negedge clk);
            if ((sel == 8) ? done8 : done1) begin
                lat = i;
                dv  = (sel == 8) ? int'(diff8) : int'(diff1);
                bo  = (sel == 8) ? int'(bout8) : int'(bout1);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 1'b1; start1 = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy8, done8, diff8, bout8} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_w8: busy=%0b done=%0b diff=%h bout=%0b required all 0", busy8, done8, diff8, bout8);
        end
        n_cmp++;
        if ({busy1, done1, diff1, bout1} !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_w1: busy=%0b done=%0b diff=%0b bout=%0b required all 0", busy1, done1, diff1, bout1);
        end
        rst_n = 1'b1;
        start8 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%0b required 0", busy8);
        end
    endtask

    task automatic test_basic();
        int va [4] = '{32'h5A, 32'h00, 32'h80, 32'hFF};
        int vb [4] = '{32'h3C, 32'h01, 32'h80, 32'h00};
        int vc [4] = '{0, 0, 1, 1};
        int ed [4] = '{32'h1E, 32'hFF, 32'hFF, 32'hFE};
        int eb [4] = '{0, 1, 1, 0};
        int lat, dv, bo;
        for (int k = 0; k < 4; k++) begin
            op(8, va[k], vb[k], vc[k], lat, dv, bo);
            n_cmp++;
            if (lat !== 8 || dv !== ed[k] || bo !== eb[k]) begin
                n_bad++;
                $display("FAIL basic_%0d: lat=%0d diff=%h bout=%0d required lat=8 diff=%h bout=%0d",
                         k, lat, dv, bo, ed[k], eb[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        int ndone = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            start8 = (c == 2) || (c == 8) || (c == 9);
            if (c == 2 || c == 8) begin
                a8 = 8'h77; b8 = 8'h11; bin8 = 1'b0;
            end else if (c == 9) begin
                a8 = 8'h33; b8 = 8'h22; bin8 = 1'b1;
            end
            if (done8) ndone++;
            if (c < 8 || (c >= 10 && c < 18)) begin
                n_cmp++;
                if (busy8 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL busy_hold_c%0d: busy=%0b required 1", c, busy8);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (done8 !== 1'b1 || diff8 !== 8'h0F || bout8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_first_done: done=%0b diff=%h bout=%0b required 1 0f 0", done8, diff8, bout8);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (busy8 !== 1'b0 || done8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_done_ignored: busy=%0b done=%0b required 0 0", busy8, done8);
                end
            end
            if (c == 18) begin
                n_cmp++;
                if (done8 !== 1'b1 || diff8 !== 8'h10 || bout8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_reaccept: done=%0b diff=%h bout=%0b required 1 10 0", done8, diff8, bout8);
                end
            end
        end
        start8 = 1'b0;
        n_cmp++;
        if (ndone !== 2) begin
            n_bad++;
            $display("FAIL busy_done_count: got %0d done pulses required 2", ndone);
        end
    endtask

    task automatic test_reset_mid();
        int lat, dv, bo;
        int seen = 0;
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            rst_n = (c == 3) ? 1'b0 : 1'b1;
            if (done8) seen++;
            if (c == 4) begin
                n_cmp++;
                if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_mid: busy=%0b done=%0b diff=%h bout=%0b required all 0",
                             busy8, done8, diff8, bout8);
                end
            end
        end
        rst_n = 1'b1;
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_nodone: got %0d done pulses required 0", seen);
        end
        op(8, 32'hC3, 32'h5A, 1, lat, dv, bo);
        n_cmp++;
        if (lat !== 8 || dv !== 32'h68 || bo !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_after: lat=%0d diff=%h bout=%0d required 8 68 0", lat, dv, bo);
        end
    endtask

    task automatic test_width1();
        int lat, dv, bo, av, bv, cv;
        for (int i = 0; i < 8; i++) begin
            av = (i >> 2) & 1; bv = (i >> 1) & 1; cv = i & 1;
            op(1, av, bv, cv, lat, dv, bo);
            n_cmp++;
            if (lat !== 1 || dv !== ref_diff(1, av, bv, cv) || bo !== ref_bout(av, bv, cv)) begin
                n_bad++;
                $display("FAIL width1_%0d%0d%0d: lat=%0d diff=%0d bout=%0d required lat=1 diff=%0d bout=%0d",
                         av, bv, cv, lat, dv, bo, ref_diff(1, av, bv, cv), ref_bout(av, bv, cv));
            end
        end
    endtask

    task automatic test_random();
        int lat, dv, bo, av, bv, cv;
        for (int k = 0; k < 1000; k++) begin
            av = int'($urandom_range(255, 0));
            bv = int'($urandom_range(255, 0));
            cv = int'($urandom_range(1, 0));
            op(8, av, bv, cv, lat, dv, bo);
            n_cmp++;
            if (lat !== 8 || dv !== ref_diff(8, av, bv, cv) || bo !== ref_bout(av, bv, cv)) begin
                n_bad++;
                $display("FAIL random_%0d: a=%h b=%h bin=%0d lat=%0d diff=%h bout=%0d required lat=8 diff=%h bout=%0d",
                         k, av, bv, cv, lat, dv, bo, ref_diff(8, av, bv, cv), ref_bout(av, bv, cv));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_start();
        test_reset_mid();
        test_width1();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
